// File: rtl/wm_panel_ctrl_if.sv
// Front-panel bus for wm_panel_ctrl: raw panel inputs and controller status
// in, conditioned controller requests and indicator LEDs out.
interface wm_panel_ctrl_if;
  logic start_btn_raw;
  logic door_sw_raw;
  logic door_lock;
  logic done;
  logic start;
  logic door_close;
  logic busy_led;
  logic done_led;
  logic err_door;
  logic err_lock;

  // Driver side: the panel/controller environment.
  modport master (
    output start_btn_raw, door_sw_raw, door_lock, done,
    input  start, door_close, busy_led, done_led, err_door, err_lock
  );

  // The conditioning block itself.
  modport slave (
    input  start_btn_raw, door_sw_raw, door_lock, done,
    output start, door_close, busy_led, done_led, err_door, err_lock
  );
endinterface

// File: rtl/wm_panel_ctrl.sv
// wm_panel_ctrl: debounces the start button and door switch, issues the start
// pulse to the washing-machine controller behind a door interlock, and drives
// the busy/done/error indicators.
// Optional: define WM_PANEL_SYNC2_EN to put a 2-flop synchronizer in front of
// each debouncer (adds two edges of latency to every raw-input path).
module wm_panel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int START_PULSE_W   = 1,
  parameter int LOCK_TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst,
  wm_panel_ctrl_if.slave  bus
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW_W = $clog2(START_PULSE_W + 1);
  localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_LOCK, S_RUN, S_DONE_HOLD
  } state_t;

  // Channel 0 = start button, channel 1 = door switch.
  logic [1:0] raw;
  logic [1:0] smp;
  assign raw = {bus.door_sw_raw, bus.start_btn_raw};

`ifdef WM_PANEL_SYNC2_EN
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  // Two-flop synchronizer for both raw panel inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end
  assign smp = sync2_q;
`else
  assign smp = raw;
`endif

  logic [1:0]      stable_q, stable_d;
  logic [1:0]      commit;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  // Debounce next-state: count consecutive samples that disagree with the
  // stable level and flip it on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      commit[i]   = 1'b0;
      if (smp[i] != stable_q[i]) begin
        if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          commit[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  state_t          state_q;
  logic [PW_W-1:0] pcnt_q;
  logic [LT_W-1:0] lcnt_q;
  logic            start_q, busy_q, done_led_q, err_door_q, err_lock_q;

  logic press, door_now, door_next, door_rise, press_ok;
  assign press     = commit[0] & stable_d[0];
  assign door_now  = stable_q[1];
  assign door_next = stable_d[1];
  assign door_rise = commit[1] & stable_d[1];
  // A press is honoured only in IDLE or DONE_HOLD with the door closed; in
  // DONE_HOLD a simultaneous door opening takes precedence.
  assign press_ok  = press & door_now &
                     ((state_q == S_IDLE) | ((state_q == S_DONE_HOLD) & door_next));

  // Request/interlock FSM with registered outputs. Error clears are written
  // before sets so a same-cycle set overrides the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pcnt_q     <= '0;
      lcnt_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_led_q <= 1'b0;
      err_door_q <= 1'b0;
      err_lock_q <= 1'b0;
    end else begin
      if (door_rise || press_ok) err_door_q <= 1'b0;
      if (press_ok)              err_lock_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (press) begin
            if (door_now) begin
              state_q <= S_REQ;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              pcnt_q  <= '0;
            end else begin
              err_door_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (!door_next) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_door_q <= 1'b1;
          end else if (pcnt_q == PW_W'(START_PULSE_W - 1)) begin
            state_q <= S_WAIT_LOCK;
            start_q <= 1'b0;
            lcnt_q  <= '0;
          end else begin
            pcnt_q <= pcnt_q + PW_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (!door_next) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            err_door_q <= 1'b1;
          end else if (bus.door_lock) begin
            state_q <= S_RUN;
          end else if (lcnt_q == LT_W'(LOCK_TIMEOUT - 1)) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            err_lock_q <= 1'b1;
          end else begin
            lcnt_q <= lcnt_q + LT_W'(1);
          end
        end
        S_RUN: begin
          if (bus.done) begin
            state_q    <= S_DONE_HOLD;
            busy_q     <= 1'b0;
            done_led_q <= 1'b1;
          end
        end
        S_DONE_HOLD: begin
          if (!door_next) begin
            state_q    <= S_IDLE;
            done_led_q <= 1'b0;
          end else if (press_ok) begin
            state_q    <= S_REQ;
            start_q    <= 1'b1;
            busy_q     <= 1'b1;
            pcnt_q     <= '0;
            done_led_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.start      = start_q;
  assign bus.door_close = stable_q[1];
  assign bus.busy_led   = busy_q;
  assign bus.done_led   = done_led_q;
  assign bus.err_door   = err_door_q;
  assign bus.err_lock   = err_lock_q;
endmodule

// File: tb/tb_wm_panel_ctrl.sv
// Self-checking bench for wm_panel_ctrl (default parameters, synchronizer off).
module tb_wm_panel_ctrl;
  localparam int DB = 4;
  localparam int PW = 1;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wm_panel_ctrl_if bus_if ();

  wm_panel_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .START_PULSE_W  (PW),
    .LOCK_TIMEOUT   (LT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_REQ = 1, M_WAIT = 2, M_RUN = 3, M_DONE = 4;
  int m_mode;
  int m_age;
  bit m_stab [2];
  int m_run  [2];
  bit m_err_door, m_err_lock;

  function automatic bit deb(int i, bit s);
    if (s == m_stab[i]) begin
      m_run[i] = 0;
      return 1'b0;
    end
    m_run[i]++;
    if (m_run[i] == DB) begin
      m_stab[i] = s;
      m_run[i]  = 0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_age = 0;
    m_stab[0] = 0; m_stab[1] = 0; m_run[0] = 0; m_run[1] = 0;
    m_err_door = 0; m_err_lock = 0;
  endfunction

  function automatic void model_step(bit r, bit b, bit d, bit l, bit n);
    bit old_door, press, door_rose, new_door, cb, cd;
    bit clr_d, set_d, clr_l, set_l;
    if (r) begin
      model_reset();
      return;
    end
    old_door  = m_stab[1];
    cb        = deb(0, b);
    cd        = deb(1, d);
    press     = cb && m_stab[0];
    new_door  = m_stab[1];
    door_rose = cd && new_door;
    clr_d = door_rose; set_d = 0; clr_l = 0; set_l = 0;
    case (m_mode)
      M_IDLE: if (press) begin
        if (old_door) begin m_mode = M_REQ; m_age = 0; clr_d = 1; clr_l = 1; end
        else set_d = 1;
      end
      M_REQ: if (!new_door) begin m_mode = M_IDLE; set_d = 1; end
             else begin m_age++; if (m_age == PW) begin m_mode = M_WAIT; m_age = 0; end end
      M_WAIT: if (!new_door) begin m_mode = M_IDLE; set_d = 1; end
              else if (l) m_mode = M_RUN;
              else begin m_age++; if (m_age == LT) begin m_mode = M_IDLE; set_l = 1; end end
      M_RUN: if (n) m_mode = M_DONE;
      M_DONE: if (!new_door) m_mode = M_IDLE;
              else if (press && old_door) begin m_mode = M_REQ; m_age = 0; clr_d = 1; clr_l = 1; end
      default: m_mode = M_IDLE;
    endcase
    if (clr_d) m_err_door = 0;
    if (set_d) m_err_door = 1;
    if (clr_l) m_err_lock = 0;
    if (set_l) m_err_lock = 1;
  endfunction

  function automatic logic [5:0] model_outs();
    return {m_mode == M_REQ, m_stab[1],
            (m_mode == M_REQ) || (m_mode == M_WAIT) || (m_mode == M_RUN),
            m_mode == M_DONE, m_err_door, m_err_lock};
  endfunction

  // ---------------- helpers ----------------
  // Output vector order: {start, door_close, busy_led, done_led, err_door, err_lock}
  function automatic logic [5:0] outs();
    return {bus_if.start, bus_if.door_close, bus_if.busy_led,
            bus_if.done_led, bus_if.err_door, bus_if.err_lock};
  endfunction

  task automatic drive(bit r, bit b, bit d, bit l, bit n);
    rst                  = r;
    bus_if.start_btn_raw = b;
    bus_if.door_sw_raw   = d;
    bus_if.door_lock     = l;
    bus_if.done          = n;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus_if.start_btn_raw, bus_if.door_sw_raw, bus_if.door_lock, bus_if.done);
    @(negedge clk);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit r, b, d, l, n;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [25];

  bit rb, rd, rl, rn, rr;

  initial begin
    // r b d l n  expected {start,door_close,busy,done_led,err_door,err_lock}
    tbl[0]  = '{1, 0, 0, 0, 0, 6'b000000};
    tbl[1]  = '{0, 0, 1, 0, 0, 6'b000000};
    tbl[2]  = '{0, 0, 1, 0, 0, 6'b000000};
    tbl[3]  = '{0, 0, 1, 0, 0, 6'b000000};
    tbl[4]  = '{0, 0, 1, 0, 0, 6'b010000};
    tbl[5]  = '{0, 1, 1, 0, 0, 6'b010000};
    tbl[6]  = '{0, 1, 1, 0, 0, 6'b010000};
    tbl[7]  = '{0, 1, 1, 0, 0, 6'b010000};
    tbl[8]  = '{0, 1, 1, 0, 0, 6'b111000};
    tbl[9]  = '{0, 1, 1, 0, 0, 6'b011000};
    tbl[10] = '{0, 0, 1, 1, 0, 6'b011000};
    tbl[11] = '{0, 0, 1, 1, 1, 6'b010100};
    tbl[12] = '{0, 0, 0, 0, 0, 6'b010100};
    tbl[13] = '{0, 0, 0, 0, 0, 6'b010100};
    tbl[14] = '{0, 0, 0, 0, 0, 6'b010100};
    tbl[15] = '{0, 0, 0, 0, 0, 6'b000000};
    tbl[16] = '{0, 1, 0, 0, 0, 6'b000000};
    tbl[17] = '{0, 1, 0, 0, 0, 6'b000000};
    tbl[18] = '{0, 1, 0, 0, 0, 6'b000000};
    tbl[19] = '{0, 1, 0, 0, 0, 6'b000010};
    tbl[20] = '{0, 1, 1, 0, 0, 6'b000010};
    tbl[21] = '{0, 1, 1, 0, 0, 6'b000010};
    tbl[22] = '{0, 1, 1, 0, 0, 6'b000010};
    tbl[23] = '{0, 1, 1, 0, 0, 6'b010000};
    tbl[24] = '{0, 0, 1, 0, 0, 6'b010000};

    drive(1, 0, 0, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].r, tbl[i].b, tbl[i].d, tbl[i].l, tbl[i].n);
      tick();
      check($sformatf("table_row%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Bounce: one start pulse, at the 4th consecutive 1.
    begin
      bit [7:0] pat;
      int pulses, first, cnt;
      pat = 8'b1111_0101;
      pulses = 0; first = -1;
      for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 0, 0); tick(); end
      for (int i = 0; i < 8; i++) begin
        drive(0, pat[i], 1, 0, 0);
        tick();
        if (bus_if.start) begin pulses++; if (first < 0) first = i; end
      end
      check("bounce_start_index", 32'(first), 32'd7);
      // Lock timeout: busy stays up for the REQ edge plus 16 WAIT_LOCK edges.
      cnt = 0;
      drive(0, 0, 1, 0, 0);
      while (bus_if.busy_led && cnt < 40) begin
        tick();
        cnt++;
        if (bus_if.start) pulses++;
      end
      check("bounce_pulse_count", 32'(pulses), 32'd1);
      check("timeout_edges", 32'(cnt), 32'd17);
      check("timeout_err_lock", 32'(bus_if.err_lock), 32'd1);
      check("timeout_outputs", 32'(outs()), 32'(6'b010001));
    end

    // Lock arriving on the timeout edge wins; then reset while in RUN.
    begin
      for (int i = 0; i < 4; i++) begin drive(0, 1, 1, 0, 0); tick(); end
      check("press_clears_err_lock", 32'(outs()), 32'(6'b111000));
      for (int i = 0; i < 16; i++) begin drive(0, 1, 1, 0, 0); tick(); end
      check("wait_lock_age15", 32'(outs()), 32'(6'b011000));
      drive(0, 1, 1, 1, 0); tick();
      check("lock_on_timeout_edge", 32'(outs()), 32'(6'b011000));
      drive(0, 1, 1, 1, 0); tick();
      check("run_holds", 32'(outs()), 32'(6'b011000));
      drive(1, 1, 1, 1, 0); tick();
      check("reset_in_run", 32'(outs()), 32'd0);
      for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 0, 0); tick(); end
      check("redebounce_door_early", 32'(bus_if.door_close), 32'd0);
      drive(0, 0, 1, 0, 0); tick();
      check("redebounce_door_edge4", 32'(outs()), 32'(6'b010000));
      // Not busy after reset: a lock/done does nothing.
      drive(0, 0, 1, 1, 1); tick();
      check("idle_ignores_done", 32'(outs()), 32'(6'b010000));
    end

    // Randomized run against the reference model.
    drive(1, 0, 0, 0, 0); tick();
    rb = 0; rd = 0; rl = 0; rn = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)  rb = ~rb;
      if ($urandom_range(0, 24) == 0) rd = ~rd;
      rl = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 5) == 0);
      rr = ($urandom_range(0, 499) == 0);
      drive(rr, rb, rd, rl, rn);
      tick();
      check($sformatf("random_cycle%0d", c), 32'(outs()), 32'(model_outs()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wm_panel_ctrl.md
# wm_panel_ctrl

Front-panel conditioning stage placed directly upstream of the washing-machine controller. It debounces the raw start button and door switch, produces the clean `door_close` level and the single-cycle `start` pulse that the controller consumes, and tracks the controller's `door_lock`/`done` outputs. From those it drives busy, done and error indicators and enforces the door interlock before a start request is issued.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive differing samples required before a debounced level changes (≥2).
- `START_PULSE_W`, default 1: width of the `start` pulse, in cycles (≥1).
- `LOCK_TIMEOUT`, default 16: cycles to wait in WAIT_LOCK for `door_lock` before aborting (≥1).
- `clk` input 1: single system clock; all state is updated on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_btn_raw` input 1: raw start button, active high, may bounce.
- `door_sw_raw` input 1: raw door switch, 1 = closed, may bounce.
- `door_lock` input 1: lock indication from the controller.
- `done` input 1: cycle-complete indication from the controller.
- `start` output 1: start pulse to the controller.
- `door_close` output 1: debounced door level to the controller.
- `busy_led` output 1: high while a cycle is being requested or is running.
- `done_led` output 1: latched cycle-complete indicator.
- `err_door` output 1: start was rejected, or the door opened during a request.
- `err_lock` output 1: the controller did not lock the door within `LOCK_TIMEOUT`.

## Operation
- Debouncer, one per raw input. Holds a stable register and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - A sample equal to the stable value clears the counter.
  - A differing sample increments the counter.
  - When the counter is at `DEBOUNCE_CYCLES-1` and the sample still differs, the stable value flips, the counter clears, and a one-cycle combinational `commit` fires.
- `door_close` is the door debouncer's stable register.
- A press is a start-debouncer commit to 1. Releases generate no event.
- FSM states: IDLE, REQ, WAIT_LOCK, RUN, DONE_HOLD.
  - IDLE: a press with `door_close`=1 goes to REQ. A press with `door_close`=0 sets `err_door` and stays in IDLE.
  - REQ: `start`=1 for `START_PULSE_W` cycles, then WAIT_LOCK.
  - WAIT_LOCK: `door_lock`=1 goes to RUN. After `LOCK_TIMEOUT` cycles without `door_lock`, set `err_lock` and go to IDLE.
  - REQ and WAIT_LOCK: if `door_close` falls, go to IDLE, set `err_door` and drop `start` immediately. This takes priority over pulse completion and over the lock/timeout checks.
  - RUN: `done`=1 goes to DONE_HOLD. Door changes and presses are ignored.
  - DONE_HOLD: `done_led`=1. If `door_close` falls, go to IDLE. If a valid press arrives (door closed), go to REQ. In both cases `done_led` is cleared.
- Presses outside IDLE and DONE_HOLD are discarded, not queued.
- `busy_led` = state ∈ {REQ, WAIT_LOCK, RUN}. It is registered alongside the state.
- `err_door` is sticky. It clears on a `door_close` commit to 1 or on a valid press.
- `err_lock` is sticky. It clears on the next valid press.
- If a clear and a set of the same error fall in the same cycle, the set wins.

## Timing
- Reset value of every output is 0, including `door_close`. Reset also sets state to IDLE and clears all counters and stable registers.
- `rst` asserted mid-operation reaches reset values at the next edge. `door_close` then re-debounces from 0, taking `DEBOUNCE_CYCLES` edges.
- Latency, macro off:
  - The stable value changes at the `DEBOUNCE_CYCLES`-th consecutive edge that samples the new raw value.
  - `start` rises at that same edge.
  - `start` falls `START_PULSE_W` edges later.
- Each sync stage adds one edge of latency (see Configuration).
- `door_lock` and `done` are sampled unsynchronised, since they come from the same clock domain.
- RUN to DONE_HOLD occurs on the first edge at which `done`=1.
- The lock timeout counter starts at 0 on entry to WAIT_LOCK. The timeout fires on the edge where the counter equals `LOCK_TIMEOUT-1`. If `door_lock`=1 on that same edge, RUN wins.

## Configuration
- `WM_PANEL_SYNC2_EN` defined: each raw input passes through a 2-flop synchronizer (reset to 0) before its debouncer. All raw-to-output latencies grow by 2 edges.
- `WM_PANEL_SYNC2_EN` undefined: raw inputs feed the debouncers directly, with no extra latency. Use only when the raw inputs are already synchronous.

## Test plan
- Reset, then `door_sw_raw`=1, then `start_btn_raw`=1 held for 8 cycles (defaults, macro off) -> `door_close` high after edge 4; `start` high for exactly 1 cycle after edge 4 of the held press; `busy_led`=1.
- Bounce: start raw toggling 1,0,1,0,1,1,1,1 with the door closed -> exactly one `start` pulse, emitted at the 4th consecutive 1.
- Press with the door open -> no `start`, `err_door`=1. Then close the door for 4 cycles -> `err_door`=0.
- After `start`, hold `door_lock`=0 for 16 cycles -> `err_lock`=1, `busy_led`=0, state IDLE.
- `door_lock`=1, then `done`=1 -> `done_led`=1, `busy_led`=0. Open the door for 4 cycles -> `done_led`=0.
- Assert `rst` for 1 cycle while in RUN -> all outputs 0 at the next edge, FSM in IDLE.
